ksa_swap: RTL

Key-scheduling stage of the RC4 datapath. It runs directly downstream of the S-array initializer, once that block has written S[i]=i into the 256x8 working RAM. For i=0..255 it computes j = j + S[i] + key[i mod KEY_LEN] (mod 256) and swaps S[i] and S[j] through the single RAM port. It then holds a done/ack handshake toward the decrypt stage.

---
 rtl/ksa_swap.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ksa_swap.sv
// rtl/ksa_swap.sv - RC4 key-scheduling swap stage over a single-port 256x8 S-array RAM
// Optional feature: define KSA_SKIP_SELF_SWAP_EN to skip the read/write phase
// of any iteration whose new j equals i (4-cycle iteration, no writes).
module ksa_swap #(
   parameter int KEY_LEN = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 done_ack,
   input  logic [8*KEY_LEN-1:0] secret_key,
   input  logic [7:0]           s_rddata,
   output logic [7:0]           s_addr,
   output logic [7:0]           s_wrdata,
   output logic                 s_wren,
   output logic                 busy,
   output logic                 ksa_done
);

   localparam int KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

   typedef enum logic [3:0] {
      IDLE, RD_I, RD_I_WAIT, CALC_J, RD_J, RD_J_WAIT, WR_I, WR_J, NEXT, DONE
   } state_t;

   state_t         state_q, state_d;
   logic [7:0]     i_q, i_d;
   logic [7:0]     j_q, j_d;
   logic [7:0]     si_q, si_d;
   logic [7:0]     sj_q, sj_d;
   logic [KW-1:0]  kidx_q, kidx_d;

   logic [7:0]     s_addr_q, s_addr_d;
   logic [7:0]     s_wrdata_q, s_wrdata_d;
   logic           s_wren_q, s_wren_d;
   logic           busy_q, busy_d;
   logic           ksa_done_q, ksa_done_d;

   logic [7:0]     key_byte;

   // Select key byte kidx; byte 0 sits in the most-significant position.
   always_comb begin
      key_byte = 8'd0;
      for (int k = 0; k < KEY_LEN; k++) begin
         if (kidx_q == KW'(k)) begin
            key_byte = secret_key[8*(KEY_LEN-k)-1 -: 8];
         end
      end
   end

   // Next-state logic, plus output values decoded from the next state so that
   // the outputs themselves are plain registers with no path from any input.
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      si_d    = si_q;
      sj_d    = sj_q;
      kidx_d  = kidx_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RD_I;
               i_d     = 8'd0;
               j_d     = 8'd0;
               kidx_d  = '0;
            end
         end
         RD_I:      state_d = RD_I_WAIT;
         RD_I_WAIT: begin
            si_d    = s_rddata;
            state_d = CALC_J;
         end
         CALC_J: begin
            j_d     = j_q + si_q + key_byte;
`ifdef KSA_SKIP_SELF_SWAP_EN
            state_d = (j_d == i_q) ? NEXT : RD_J;
`else
            state_d = RD_J;
`endif
         end
         RD_J:      state_d = RD_J_WAIT;
         RD_J_WAIT: begin
            sj_d    = s_rddata;
            state_d = WR_I;
         end
         WR_I:      state_d = WR_J;
         WR_J:      state_d = NEXT;
         NEXT: begin
            i_d     = i_q + 8'd1;
            kidx_d  = (kidx_q == KW'(KEY_LEN-1)) ? '0 : kidx_q + KW'(1);
            state_d = (i_q == 8'hff) ? DONE : RD_I;
         end
         DONE: begin
            if (done_ack) begin
               state_d = IDLE;
            end
         end
         default:   state_d = IDLE;
      endcase

      s_addr_d   = i_d;
      s_wrdata_d = 8'd0;
      s_wren_d   = 1'b0;
      case (state_d)
         RD_J, RD_J_WAIT: s_addr_d = j_d;
         WR_I: begin
            s_addr_d   = i_d;
            s_wrdata_d = sj_d;
            s_wren_d   = 1'b1;
         end
         WR_J: begin
            s_addr_d   = j_d;
            s_wrdata_d = si_d;
            s_wren_d   = 1'b1;
         end
         default: ;
      endcase
      busy_d     = (state_d != IDLE) && (state_d != DONE);
      ksa_done_d = (state_d == DONE);
   end

   // State, datapath and output registers; reset returns to IDLE at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         i_q        <= 8'd0;
         j_q        <= 8'd0;
         si_q       <= 8'd0;
         sj_q       <= 8'd0;
         kidx_q     <= '0;
         s_addr_q   <= 8'd0;
         s_wrdata_q <= 8'd0;
         s_wren_q   <= 1'b0;
         busy_q     <= 1'b0;
         ksa_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         i_q        <= i_d;
         j_q        <= j_d;
         si_q       <= si_d;
         sj_q       <= sj_d;
         kidx_q     <= kidx_d;
         s_addr_q   <= s_addr_d;
         s_wrdata_q <= s_wrdata_d;
         s_wren_q   <= s_wren_d;
         busy_q     <= busy_d;
         ksa_done_q <= ksa_done_d;
      end
   end

   assign s_addr   = s_addr_q;
   assign s_wrdata = s_wrdata_q;
   assign s_wren   = s_wren_q;
   assign busy     = busy_q;
   assign ksa_done = ksa_done_q;

endmodule
